// File: rtl/cr16_mmio_pkg.sv
// Shared register offsets and bit positions for the CR16 MMIO responder.
// Timer support is built only when CR16_MMIO_TIMER_EN is defined.
package cr16_mmio_pkg;

  localparam logic [2:0] P_MMIO_OFS_DISP_LO       = 3'd0;
  localparam logic [2:0] P_MMIO_OFS_DISP_HI       = 3'd1;
  localparam logic [2:0] P_MMIO_OFS_LED           = 3'd2;
  localparam logic [2:0] P_MMIO_OFS_SWITCH        = 3'd3;
  localparam logic [2:0] P_MMIO_OFS_BTN_EVENT     = 3'd4;
  localparam logic [2:0] P_MMIO_OFS_TIMER_COUNT   = 3'd5;
  localparam logic [2:0] P_MMIO_OFS_TIMER_CTRL    = 3'd6;
  localparam logic [2:0] P_MMIO_OFS_TIMER_COMPARE = 3'd7;

  localparam int P_MMIO_REGION_WORDS = 8;

  localparam int P_CTRL_ENABLE_BIT = 0;
  localparam int P_CTRL_CLEAR_BIT  = 1;
  localparam int P_EVENT_MATCH_BIT = 15;

endpackage

// File: rtl/cr16_mmio_input_sync.sv
// Two-flop synchronizer for asynchronous inputs, plus a one-cycle pulse
// whenever the synchronized level falls from 1 to 0.
module cr16_mmio_input_sync
  import cr16_mmio_pkg::*;
#(
  parameter int P_WIDTH = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [P_WIDTH-1:0] raw,
  output logic [P_WIDTH-1:0] level,
  output logic [P_WIDTH-1:0] fall
);

  logic [P_WIDTH-1:0] meta;
  logic [P_WIDTH-1:0] level_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta       <= '0;
      level      <= '0;
      level_prev <= '0;
    end else begin
      meta       <= raw;
      level      <= meta;
      level_prev <= level;
    end
  end

  // Reset clears level_prev too, so the 0->1 settle after reset never looks like a press.
  assign fall = level_prev & ~level;

endmodule

// File: rtl/cr16_mmio_responder.sv
// Memory-mapped display/LED/switch/button/timer registers on the CR16 external bus.
// Define CR16_MMIO_TIMER_EN to build the timer, compare match flag and IRQ.
module cr16_mmio_responder
  import cr16_mmio_pkg::*;
#(
  parameter logic [15:0] P_BASE_ADDRESS   = 16'hFF00,
  parameter logic [15:0] P_TIMER_PRESCALE = 16'd50000,
  parameter int          P_NUM_BUTTONS    = 4
) (
  input  logic                     I_CLK,
  input  logic                     I_RESET,
  input  logic [15:0]              I_EXT_MEM_ADDRESS,
  input  logic [15:0]              I_EXT_MEM_DATA,
  input  logic                     I_EXT_MEM_WRITE_ENABLE,
  output logic [15:0]              O_EXT_MEM_DATA,
  input  logic [9:0]               I_SWITCHES,
  input  logic [P_NUM_BUTTONS-1:0] I_BUTTONS_N,
  output logic [23:0]              O_DISPLAY_BITS,
  output logic [9:0]               O_LEDS,
  output logic                     O_TIMER_IRQ
);

  logic [15:0] rel_addr;
  logic        hit;
  logic [2:0]  offset;
  logic        wr_hit;

  // Subtracting first makes a region that straddles 16'hFFFF->0 decode correctly.
  assign rel_addr = I_EXT_MEM_ADDRESS - P_BASE_ADDRESS;
  assign hit      = rel_addr < 16'(P_MMIO_REGION_WORDS);
  assign offset   = rel_addr[2:0];
  assign wr_hit   = I_EXT_MEM_WRITE_ENABLE && hit;

  logic [9:0]               sw_level;
  logic [9:0]               sw_fall;
  logic [P_NUM_BUTTONS-1:0] btn_level;
  logic [P_NUM_BUTTONS-1:0] btn_press;

  cr16_mmio_input_sync #(.P_WIDTH(10)) u_switch_sync (
    .clk   (I_CLK),
    .reset (I_RESET),
    .raw   (I_SWITCHES),
    .level (sw_level),
    .fall  (sw_fall)
  );

  cr16_mmio_input_sync #(.P_WIDTH(P_NUM_BUTTONS)) u_button_sync (
    .clk   (I_CLK),
    .reset (I_RESET),
    .raw   (I_BUTTONS_N),
    .level (btn_level),
    .fall  (btn_press)
  );

  logic unused_sync;
  assign unused_sync = ^{sw_fall, btn_level};

  logic [15:0]              disp_lo;
  logic [7:0]               disp_hi;
  logic [9:0]               leds;
  logic [P_NUM_BUTTONS-1:0] btn_event;
  logic [P_NUM_BUTTONS-1:0] btn_clear;

  assign btn_clear = (wr_hit && offset == P_MMIO_OFS_BTN_EVENT) ?
                     I_EXT_MEM_DATA[P_NUM_BUTTONS-1:0] : '0;

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      disp_lo   <= '0;
      disp_hi   <= '0;
      leds      <= '0;
      btn_event <= '0;
    end else begin
      if (wr_hit && offset == P_MMIO_OFS_DISP_LO) disp_lo <= I_EXT_MEM_DATA;
      if (wr_hit && offset == P_MMIO_OFS_DISP_HI) disp_hi <= I_EXT_MEM_DATA[7:0];
      if (wr_hit && offset == P_MMIO_OFS_LED)     leds    <= I_EXT_MEM_DATA[9:0];
      // OR-ing the press in after the clear lets a same-cycle press survive W1C.
      btn_event <= (btn_event & ~btn_clear) | btn_press;
    end
  end

  logic [15:0] timer_count_rd;
  logic [15:0] timer_ctrl_rd;
  logic [15:0] timer_compare_rd;
  logic        match_flag;

`ifdef CR16_MMIO_TIMER_EN
  logic [15:0] prescaler;
  logic [15:0] timer_count;
  logic [15:0] timer_compare;
  logic        timer_enable;
  logic        ctrl_write;
  logic        timer_clear;
  logic        tick;
  logic [15:0] count_next;
  logic        match_set;
  logic        match_clear;

  assign ctrl_write  = wr_hit && offset == P_MMIO_OFS_TIMER_CTRL;
  assign timer_clear = ctrl_write && I_EXT_MEM_DATA[P_CTRL_CLEAR_BIT];
  assign tick        = timer_enable && (prescaler == P_TIMER_PRESCALE - 16'd1);
  assign count_next  = timer_count + 16'd1;
  // Only an actual increment onto the compare value raises the flag.
  assign match_set   = tick && !timer_clear && (count_next == timer_compare);
  assign match_clear = wr_hit && offset == P_MMIO_OFS_BTN_EVENT &&
                       I_EXT_MEM_DATA[P_EVENT_MATCH_BIT];

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      prescaler     <= '0;
      timer_count   <= '0;
      timer_compare <= '0;
      timer_enable  <= 1'b0;
      match_flag    <= 1'b0;
    end else begin
      if (ctrl_write) timer_enable <= I_EXT_MEM_DATA[P_CTRL_ENABLE_BIT];
      if (timer_clear) begin
        prescaler   <= '0;
        timer_count <= '0;
      end else if (tick) begin
        prescaler   <= '0;
        timer_count <= count_next;
      end else if (timer_enable) begin
        prescaler <= prescaler + 16'd1;
      end
      if (wr_hit && offset == P_MMIO_OFS_TIMER_COMPARE) timer_compare <= I_EXT_MEM_DATA;
      if (match_set) match_flag <= 1'b1;
      else if (match_clear) match_flag <= 1'b0;
    end
  end

  assign timer_count_rd   = timer_count;
  assign timer_ctrl_rd    = {15'd0, timer_enable};
  assign timer_compare_rd = timer_compare;
`else
  logic unused_prescale;
  assign unused_prescale  = ^P_TIMER_PRESCALE;
  assign timer_count_rd   = '0;
  assign timer_ctrl_rd    = '0;
  assign timer_compare_rd = '0;
  assign match_flag       = 1'b0;
`endif

  logic [15:0] event_word;
  logic [15:0] rdata;

  always_comb begin
    event_word = '0;
    event_word[P_NUM_BUTTONS-1:0] = btn_event;
    event_word[P_EVENT_MATCH_BIT] = match_flag;
  end

  always_comb begin
    rdata = '0;
    case (offset)
      P_MMIO_OFS_DISP_LO:       rdata = disp_lo;
      P_MMIO_OFS_DISP_HI:       rdata = {8'd0, disp_hi};
      P_MMIO_OFS_LED:           rdata = {6'd0, leds};
      P_MMIO_OFS_SWITCH:        rdata = {6'd0, sw_level};
      P_MMIO_OFS_BTN_EVENT:     rdata = event_word;
      P_MMIO_OFS_TIMER_COUNT:   rdata = timer_count_rd;
      P_MMIO_OFS_TIMER_CTRL:    rdata = timer_ctrl_rd;
      P_MMIO_OFS_TIMER_COMPARE: rdata = timer_compare_rd;
      default:                  rdata = '0;
    endcase
  end

  // Sampled before this edge's writes land, so a concurrent read returns the old value.
  always_ff @(posedge I_CLK) begin
    if (I_RESET) O_EXT_MEM_DATA <= '0;
    else         O_EXT_MEM_DATA <= hit ? rdata : 16'h0000;
  end

  assign O_DISPLAY_BITS = {disp_hi, disp_lo};
  assign O_LEDS         = leds;
  assign O_TIMER_IRQ    = match_flag;

endmodule
